// File: rtl/matmul_ctrl.sv
// Sequencing controller for an N x N matrix multiply: walks X/Y BRAMs, feeds one MAC lane, writes Z.
// Optional macro MATMUL_CTRL_MULT_PIPE_EN adds a register between the multiplier and the accumulator.
module matmul_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int VECTOR_SIZE = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] x_rd_addr,
  input  logic [DATA_WIDTH-1:0] x_dout,
  output logic [ADDR_WIDTH-1:0] y_rd_addr,
  input  logic [DATA_WIDTH-1:0] y_dout,
  output logic [ADDR_WIDTH-1:0] z_wr_addr,
  output logic                  z_wr_en,
  output logic [DATA_WIDTH-1:0] z_din
);

  localparam int N  = VECTOR_SIZE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            r_state;
  logic                  r_done;
  logic [IW-1:0]         r_i, r_j, r_k;
  logic [ADDR_WIDTH-1:0] r_x_rd_addr, r_y_rd_addr;

  // Issue stage: tags travel alongside the BRAM addresses.
  logic                  r_iss_vld, r_iss_first, r_iss_last, r_iss_final;
  logic [ADDR_WIDTH-1:0] r_iss_zaddr;
  // Data stage: BRAM outputs belong to these tags.
  logic                  r_d_vld, r_d_first, r_d_last, r_d_final;
  logic [ADDR_WIDTH-1:0] r_d_zaddr;

  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_z_wr_en, r_z_final;
  logic [ADDR_WIDTH-1:0] r_z_wr_addr;
  logic [DATA_WIDTH-1:0] r_z_din;

  logic                  w_accept, w_issue;
  logic [IW-1:0]         w_i, w_j, w_k;
  logic [IW-1:0]         w_i_nxt, w_j_nxt, w_k_nxt;
  logic                  w_i_last, w_j_last, w_k_last, w_term_final;
  logic [ADDR_WIDTH-1:0] w_x_addr, w_y_addr, w_z_addr;
  logic [DATA_WIDTH-1:0] w_p, w_sum;

  logic                  w_a_vld, w_a_first, w_a_last, w_a_final;
  logic [ADDR_WIDTH-1:0] w_a_zaddr;
  logic [DATA_WIDTH-1:0] w_a_p;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_issue  = w_accept || (r_state == S_RUN);
    w_i      = w_accept ? '0 : r_i;
    w_j      = w_accept ? '0 : r_j;
    w_k      = w_accept ? '0 : r_k;

    w_i_last     = (w_i == LAST_IDX);
    w_j_last     = (w_j == LAST_IDX);
    w_k_last     = (w_k == LAST_IDX);
    w_term_final = w_i_last && w_j_last && w_k_last;

    w_k_nxt = w_k_last ? '0 : w_k + 1'b1;
    w_j_nxt = w_k_last ? (w_j_last ? '0 : w_j + 1'b1) : w_j;
    w_i_nxt = (w_k_last && w_j_last) ? (w_i_last ? '0 : w_i + 1'b1) : w_i;

    w_x_addr = ADDR_WIDTH'(w_i) * ADDR_WIDTH'(N) + ADDR_WIDTH'(w_k);
    w_y_addr = ADDR_WIDTH'(w_k) * ADDR_WIDTH'(N) + ADDR_WIDTH'(w_j);
    w_z_addr = ADDR_WIDTH'(w_i) * ADDR_WIDTH'(N) + ADDR_WIDTH'(w_j);
  end

  // Product is taken modulo 2**DATA_WIDTH by the assignment width.
  assign w_p = x_dout * y_dout;

`ifdef MATMUL_CTRL_MULT_PIPE_EN
  logic                  r_m_vld, r_m_first, r_m_last, r_m_final;
  logic [ADDR_WIDTH-1:0] r_m_zaddr;
  logic [DATA_WIDTH-1:0] r_m_p;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_m_vld   <= 1'b0;
      r_m_first <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_final <= 1'b0;
      r_m_zaddr <= '0;
      r_m_p     <= '0;
    end else begin
      r_m_vld   <= r_d_vld;
      r_m_first <= r_d_first;
      r_m_last  <= r_d_last;
      r_m_final <= r_d_final;
      r_m_zaddr <= r_d_zaddr;
      r_m_p     <= w_p;
    end
  end

  assign w_a_vld   = r_m_vld;
  assign w_a_first = r_m_first;
  assign w_a_last  = r_m_last;
  assign w_a_final = r_m_final;
  assign w_a_zaddr = r_m_zaddr;
  assign w_a_p     = r_m_p;
`else
  assign w_a_vld   = r_d_vld;
  assign w_a_first = r_d_first;
  assign w_a_last  = r_d_last;
  assign w_a_final = r_d_final;
  assign w_a_zaddr = r_d_zaddr;
  assign w_a_p     = w_p;
`endif

  assign w_sum = r_acc + w_a_p;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_done      <= 1'b0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_x_rd_addr <= '0;
      r_y_rd_addr <= '0;
      r_iss_vld   <= 1'b0;
      r_iss_first <= 1'b0;
      r_iss_last  <= 1'b0;
      r_iss_final <= 1'b0;
      r_iss_zaddr <= '0;
      r_d_vld     <= 1'b0;
      r_d_first   <= 1'b0;
      r_d_last    <= 1'b0;
      r_d_final   <= 1'b0;
      r_d_zaddr   <= '0;
      r_acc       <= '0;
      r_z_wr_en   <= 1'b0;
      r_z_final   <= 1'b0;
      r_z_wr_addr <= '0;
      r_z_din     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= w_term_final ? S_DRAIN : S_RUN;
            r_done  <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_term_final) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_z_wr_en && r_z_final) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_issue) begin
        r_i         <= w_i_nxt;
        r_j         <= w_j_nxt;
        r_k         <= w_k_nxt;
        r_x_rd_addr <= w_x_addr;
        r_y_rd_addr <= w_y_addr;
        r_iss_zaddr <= w_z_addr;
      end
      r_iss_vld   <= w_issue;
      r_iss_first <= w_issue && (w_k == '0);
      r_iss_last  <= w_issue && w_k_last;
      r_iss_final <= w_issue && w_term_final;

      r_d_vld   <= r_iss_vld;
      r_d_first <= r_iss_first;
      r_d_last  <= r_iss_last;
      r_d_final <= r_iss_final;
      r_d_zaddr <= r_iss_zaddr;

      if (w_a_vld) r_acc <= w_a_first ? w_a_p : w_sum;
      r_z_wr_en <= w_a_vld && w_a_last;
      r_z_final <= w_a_vld && w_a_last && w_a_final;
      if (w_a_vld && w_a_last) begin
        r_z_din     <= w_a_first ? w_a_p : w_sum;
        r_z_wr_addr <= w_a_zaddr;
      end
    end
  end

  assign done      = r_done;
  assign x_rd_addr = r_x_rd_addr;
  assign y_rd_addr = r_y_rd_addr;
  assign z_wr_addr = r_z_wr_addr;
  assign z_wr_en   = r_z_wr_en;
  assign z_din     = r_z_din;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl: BRAM models, reference matmul scoreboard, timing checks.
module tb_matmul_ctrl;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int N  = 8;
  localparam int NN = N * N;
`ifdef MATMUL_CTRL_MULT_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif
  localparam int LAT = N * N * N + 2 + PIPE;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          done;
  logic [AW-1:0] x_rd_addr, y_rd_addr, z_wr_addr;
  logic [DW-1:0] x_dout, y_dout, z_din;
  logic          z_wr_en;

  logic [DW-1:0] x_mem [NN];
  logic [DW-1:0] y_mem [NN];
  logic [DW-1:0] z_mem [NN];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } z_exp_t;
  z_exp_t sb[$];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  matmul_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VECTOR_SIZE(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .x_rd_addr (x_rd_addr),
    .x_dout    (x_dout),
    .y_rd_addr (y_rd_addr),
    .y_dout    (y_dout),
    .z_wr_addr (z_wr_addr),
    .z_wr_en   (z_wr_en),
    .z_din     (z_din)
  );

  // Synchronous-read BRAM models with one cycle of read latency.
  always @(posedge clock) begin
    x_dout <= x_mem[x_rd_addr];
    y_dout <= y_mem[y_rd_addr];
    if (z_wr_en) z_mem[z_wr_addr] <= z_din;
  end

  task automatic push_expected();
    logic [DW-1:0] acc;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int k = 0; k < N; k++) acc = acc + x_mem[i*N+k] * y_mem[k*N+j];
        sb.push_back('{AW'(i*N+j), acc});
      end
    end
  endtask

  task automatic run_matmul(input string name, input int extra_start_cyc);
    int     cyc;
    int     e;
    int     lat;
    z_exp_t ex;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_on_accept: got %b expected 0", name, done);
    end
    cyc = 0;
    e   = 0;
    lat = -1;
    while (cyc < LAT + 200) begin
      @(negedge clock);
      cyc++;
      start = (cyc == extra_start_cyc);
      if (z_wr_en === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s extra_write: addr %0d data %h at cycle %0d", name, z_wr_addr, z_din, cyc);
        end else begin
          ex = sb.pop_front();
          if (z_din !== ex.data || z_wr_addr !== ex.addr || cyc != (e + 1) * N + 1 + PIPE) begin
            errors++;
            $display("FAIL %s z_write[%0d]: got addr %0d data %h cycle %0d expected addr %0d data %h cycle %0d",
                     name, e, z_wr_addr, z_din, cyc, ex.addr, ex.data, (e + 1) * N + 1 + PIPE);
          end
        end
        e++;
      end
      if (done === 1'b1) begin
        lat = cyc;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
    end
    checks++;
    if (e != NN || sb.size() != 0) begin
      errors++;
      $display("FAIL %s write_count: got %0d writes, %0d pending expected %0d writes, 0 pending",
               name, e, sb.size(), NN);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (done !== 1'b0 || z_wr_en !== 1'b0 || x_rd_addr !== '0 || y_rd_addr !== '0 ||
        z_wr_addr !== '0 || z_din !== '0) begin
      errors++;
      $display("FAIL reset_values: got done %b we %b xa %0d ya %0d za %0d din %h expected all 0",
               done, z_wr_en, x_rd_addr, y_rd_addr, z_wr_addr, z_din);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_identity();
    for (int a = 0; a < NN; a++) begin
      x_mem[a] = ((a / N) == (a % N)) ? 32'd1 : 32'd0;
      y_mem[a] = DW'(a);
      z_mem[a] = 32'hDEAD_BEEF;
    end
    push_expected();
    run_matmul("identity", -1);
    for (int a = 0; a < NN; a++) begin
      checks++;
      if (z_mem[a] !== DW'(a)) begin
        errors++;
        $display("FAIL identity z_mem[%0d]: got %h expected %h", a, z_mem[a], DW'(a));
      end
    end
  endtask

  task automatic test_ones();
    for (int a = 0; a < NN; a++) begin
      x_mem[a] = 32'd1;
      y_mem[a] = 32'd1;
    end
    push_expected();
    run_matmul("ones", -1);
    for (int a = 0; a < NN; a++) begin
      checks++;
      if (z_mem[a] !== 32'h0000_0008) begin
        errors++;
        $display("FAIL ones z_mem[%0d]: got %h expected 00000008", a, z_mem[a]);
      end
    end
  endtask

  task automatic test_wrap();
    for (int a = 0; a < NN; a++) begin
      x_mem[a] = 32'hFFFF_FFFF;
      y_mem[a] = 32'd1;
    end
    push_expected();
    run_matmul("wrap", -1);
    for (int a = 0; a < NN; a++) begin
      checks++;
      if (z_mem[a] !== 32'hFFFF_FFF8) begin
        errors++;
        $display("FAIL wrap z_mem[%0d]: got %h expected fffffff8", a, z_mem[a]);
      end
    end
  endtask

  task automatic test_start_ignored();
    for (int a = 0; a < NN; a++) begin
      x_mem[a] = $urandom;
      y_mem[a] = $urandom;
    end
    push_expected();
    run_matmul("start_in_run", 100);
  endtask

  task automatic test_mid_reset();
    for (int a = 0; a < NN; a++) begin
      x_mem[a] = $urandom_range(0, 255);
      y_mem[a] = $urandom_range(0, 255);
    end
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (199) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || z_wr_en !== 1'b0 || x_rd_addr !== '0 || y_rd_addr !== '0 ||
        z_wr_addr !== '0 || z_din !== '0) begin
      errors++;
      $display("FAIL mid_reset_values: got done %b we %b xa %0d ya %0d za %0d din %h expected all 0",
               done, z_wr_en, x_rd_addr, y_rd_addr, z_wr_addr, z_din);
    end
    reset = 1'b0;
    for (int c = 0; c < 2 * N; c++) begin
      @(negedge clock);
      checks++;
      if (z_wr_en !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_idle[%0d]: got we %b done %b expected 0 0", c, z_wr_en, done);
      end
    end
    push_expected();
    run_matmul("after_reset", -1);
  endtask

  task automatic test_back_to_back();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_held: got %b expected 1", done);
    end
    for (int a = 0; a < NN; a++) begin
      x_mem[a] = $urandom;
      y_mem[a] = $urandom;
    end
    push_expected();
    run_matmul("back_to_back", -1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_identity();
    test_ones();
    test_wrap();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
